// File: rtl/risc_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the StCheck state.
package risc_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned IMEM_DEPTH     = 256;
  localparam int unsigned BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } loader_state_e;
`endif

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, load control and instruction-memory write port of the loader.
// master drives start/len/bytes; slave is the loader itself.
interface imem_loader_if;
  import risc_pkg::*;

  logic            start;
  logic [XLEN-1:0] len;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            busy;
  logic            cpu_hold;
  logic            done;
  logic            err;

  modport master (
    output start, len, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err
  );

  modport slave (
    input  start, len, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Packs bytes little-endian into one instruction word; word_full_o flags the
// cycle in which the final lane is being filled.
module imem_word_assembler
  import risc_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [7:0]      byte_i,
  output logic [XLEN-1:0] word_o,
  output logic            word_full_o
);

  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

  logic [LaneW-1:0] lane_q, lane_d;
  logic [XLEN-1:0]  word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (push_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = push_i && (lane_q == LaneW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream into instruction memory, holding the core while busy.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import risc_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  imem_loader_if.slave bus
);

  localparam int unsigned CntW = $clog2(IMEM_DEPTH);

  loader_state_e   state_q, state_d;
  logic [CntW-1:0] last_q, last_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic            err_q, err_d;
  logic            asm_clear, asm_push, asm_full;
  logic [XLEN-1:0] asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  imem_word_assembler u_word_assembler (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (asm_clear),
    .push_i      (asm_push),
    .byte_i      (bus.byte_data),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    asm_clear  = 1'b0;
    asm_push   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.len > XLEN'(IMEM_DEPTH)) begin
            err_d = 1'b1;
          end else if (bus.len != '0) begin
            // Store len-1 so the 256-word maximum fits the word counter width.
            last_d     = CntW'(bus.len - XLEN'(1));
            word_cnt_d = '0;
            err_d      = 1'b0;
            asm_clear  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = StRecv;
          end
        end
      end
      StRecv: begin
        asm_push = bus.byte_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (bus.byte_valid) csum_d = csum_q ^ bus.byte_data;
`endif
        if (asm_full) state_d = StWrite;
      end
      StWrite: begin
        if (word_cnt_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          asm_clear  = 1'b1;
          state_d    = StRecv;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (bus.byte_valid) begin
          if (bus.byte_data != csum_q) err_d = 1'b1;
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      last_q     <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // All outputs decode from flops only; byte_valid never reaches byte_ready.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.byte_ready = (state_q == StRecv) || (state_q == StCheck);
`else
  assign bus.byte_ready = (state_q == StRecv);
`endif
  assign bus.mem_we    = (state_q == StWrite);
  assign bus.mem_addr  = XLEN'(word_cnt_q);
  assign bus.mem_wdata = asm_word;
  assign bus.busy      = (state_q != StIdle);
  assign bus.cpu_hold  = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;

endmodule
